// File: rtl/raymarch_pixel_scheduler.sv
// rtl/raymarch_pixel_scheduler.sv - raster-order pixel sequencer between raymarcher core and framebuffer
//
// Walks every pixel of a WIDTH x HEIGHT frame, issues each coordinate to the
// raymarcher, waits for its pixel_done, captures the RGB result and writes it
// to the framebuffer through a valid/ready port.
//
// Optional feature macro: PIXEL_TIMEOUT_EN
//   When defined, a per-pixel watchdog substitutes magenta (24'hFF00FF) for any
//   pixel whose rm_done_in does not arrive within TIMEOUT cycles of WAIT.
//
// Ports:
//   clk_in          in   system clock
//   rst_in          in   asynchronous active-high reset
//   start_in        in   begin a frame (sampled in IDLE only)
//   continuous_in   in   restart immediately at end of frame
//   rm_valid_out    out  one-cycle pulse, new pixel issued
//   rm_x_out        out  pixel x, stable from issue until write accepted
//   rm_y_out        out  pixel y, stable from issue until write accepted
//   rm_done_in      in   raymarcher pixel_done pulse
//   rm_rgb_in       in   {r,g,b} valid with rm_done_in
//   fb_we_out       out  framebuffer write valid
//   fb_addr_out     out  y*WIDTH + x
//   fb_data_out     out  captured {r,g,b}
//   fb_ready_in     in   framebuffer accepts write
//   frame_start_out out  pulse when pixel (0,0) is issued
//   frame_done_out  out  pulse when the last pixel write is accepted
//   busy_out        out  high in any state except IDLE

module raymarch_pixel_scheduler #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 180,
    parameter int TIMEOUT = 4096,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic          continuous_in,
    output logic          rm_valid_out,
    output logic [XW-1:0] rm_x_out,
    output logic [YW-1:0] rm_y_out,
    input  logic          rm_done_in,
    input  logic [23:0]   rm_rgb_in,
    output logic          fb_we_out,
    output logic [AW-1:0] fb_addr_out,
    output logic [23:0]   fb_data_out,
    input  logic          fb_ready_in,
    output logic          frame_start_out,
    output logic          frame_done_out,
    output logic          busy_out
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] W_AW   = AW'(WIDTH);
    localparam logic [23:0]   MAGENTA = 24'hFF00FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t        state_q, state_nx;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [23:0]   data_q;
    logic          last_px;
    logic          accept;
    logic          timeout_hit;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);
    assign accept  = (state_q == S_WRITE) && fb_ready_in;

`ifdef PIXEL_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] cnt_q;

    // Real data arriving on the same cycle as expiry takes priority.
    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == TW'(TIMEOUT - 1)) && !rm_done_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_nx        = state_q;
        rm_valid_out    = 1'b0;
        frame_start_out = 1'b0;
        fb_we_out       = 1'b0;
        frame_done_out  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                rm_valid_out    = 1'b1;
                frame_start_out = (x_q == '0) && (y_q == '0);
                state_nx        = S_WAIT;
            end
            S_WAIT: begin
                if (rm_done_in || timeout_hit) state_nx = S_WRITE;
            end
            S_WRITE: begin
                fb_we_out = 1'b1;
                if (fb_ready_in) begin
                    if (last_px) begin
                        frame_done_out = 1'b1;
                        state_nx       = continuous_in ? S_ISSUE : S_IDLE;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_nx;
            if (state_q == S_IDLE && start_in) begin
                x_q <= '0;
                y_q <= '0;
            end
            if (state_q == S_WAIT) begin
                if (rm_done_in) data_q <= rm_rgb_in;
                else if (timeout_hit) data_q <= MAGENTA;
            end
            if (accept) begin
                if (last_px) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    assign rm_x_out    = x_q;
    assign rm_y_out    = y_q;
    assign fb_data_out = data_q;
    assign fb_addr_out = AW'(y_q) * W_AW + AW'(x_q);
    assign busy_out    = (state_q != S_IDLE);

endmodule
